// File: rtl/recon_ctrl_pkg.sv
// Shared types and helpers for the modulo-ADC reconstruction pipeline sequencer.
package recon_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } seq_state_e;

  typedef logic [1:0] order_t;

  // Order 0 is meaningless to the datapath and is treated as first order.
  function automatic order_t map_order(input order_t n);
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

  function automatic int unsigned fill_len(input order_t n,
                                           input int unsigned first_two,
                                           input int unsigned stage,
                                           input int unsigned tail);
    return first_two + stage * 32'(n) + tail;
  endfunction

endpackage

// File: rtl/recon_tick_divider.sv
// Sample-rate tick generator: registered one-clk pulse every DIV enabled clocks.
module recon_tick_divider #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // tick_next_o lets the parent act on the same edge the tick registers.
  assign tick_next_o = enable_i && !clear_i && (cnt_q == LAST);
  assign tick_o      = tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_next_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_next_o;
    end
  end

endmodule

// File: rtl/recon_pipeline_sequencer.sv
// Sequencer for the reconstruction datapath: sample ticks, start, pipeline
// reset, order application and flush/refill with output-valid masking.
module recon_pipeline_sequencer
  import recon_ctrl_pkg::*;
#(
  parameter int unsigned DIV             = 50,
  parameter int unsigned FLUSH_CYCLES    = 4,
  parameter int unsigned FIRST_TWO_DELAY = 16,
  parameter int unsigned STAGE_DELAY     = 44,
  parameter int unsigned TAIL_DELAY      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_n,
  output logic       cfg_ready,
  output logic       pipe_reset,
  output logic       clk_en,
  output logic       start,
  output logic [1:0] n_out,
  input  logic       data_valid_in,
  output logic       out_valid,
  output logic [1:0] state
);

  localparam int unsigned MAX_FILL = FIRST_TWO_DELAY + 3 * STAGE_DELAY + TAIL_DELAY;
  localparam int unsigned FILL_W   = $clog2(MAX_FILL + 1);
  localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  if (DIV < 1 || DIV > 1023) begin : g_bad_div
    $error("recon_pipeline_sequencer: DIV must be 1..1023");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_bad_flush
    $error("recon_pipeline_sequencer: FLUSH_CYCLES must be 1..255");
  end
  if (longint'(FIRST_TWO_DELAY) + 3 * longint'(STAGE_DELAY) + longint'(TAIL_DELAY)
      != longint'(MAX_FILL) || MAX_FILL == 0) begin : g_bad_fill
    $error("recon_pipeline_sequencer: fill length overflows its unsigned range");
  end

  seq_state_e        state_q, state_d;
  order_t            n_out_q, n_out_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              pipe_reset_q, pipe_reset_d;
  logic              start_q, start_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              accept, order_change, leave_ticking, tick_run, tick_next;
  order_t            cfg_mapped;
  logic [FILL_W-1:0] fill_last;

  assign accept       = cfg_valid && cfg_ready_q;
  assign cfg_mapped   = map_order(cfg_n);
  assign order_change = (state_q == RUN) && accept && (cfg_mapped != n_out_q);
  // Kept free of the tick so the divider enable never loops back through state_d.
  assign leave_ticking = !run || order_change;
  assign tick_run      = (state_q inside {FILL, RUN}) && !leave_ticking;
  assign fill_last     = FILL_W'(fill_len(n_out_q, FIRST_TWO_DELAY, STAGE_DELAY, TAIL_DELAY) - 1);

  recon_tick_divider #(
    .DIV(DIV)
  ) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (!tick_run),
    .enable_i   (tick_run),
    .tick_o     (clk_en),
    .tick_next_o(tick_next)
  );

  always_comb begin
    state_d     = state_q;
    n_out_d     = accept ? cfg_mapped : n_out_q;
    flush_cnt_d = (state_q == FLUSH) ? flush_cnt_q + 8'd1 : 8'd0;
    fill_cnt_d  = '0;
    if (state_q == FILL) begin
      fill_cnt_d = tick_next ? fill_cnt_q + FILL_W'(1) : fill_cnt_q;
    end

    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FLUSH;
        FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = FILL;
        FILL:    if (tick_next && (fill_cnt_q == fill_last)) state_d = RUN;
        RUN:     if (order_change) state_d = FLUSH;
        default: state_d = IDLE;
      endcase
    end

    pipe_reset_d = state_d inside {IDLE, FLUSH};
    start_d      = state_d inside {FILL, RUN};
    cfg_ready_d  = state_d inside {IDLE, RUN};
    out_valid_d  = (state_q == RUN) && (state_d == RUN) && clk_en && data_valid_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      n_out_q      <= 2'd1;
      flush_cnt_q  <= '0;
      fill_cnt_q   <= '0;
      pipe_reset_q <= 1'b1;
      start_q      <= 1'b0;
      cfg_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_out_q      <= n_out_d;
      flush_cnt_q  <= flush_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      pipe_reset_q <= pipe_reset_d;
      start_q      <= start_d;
      cfg_ready_q  <= cfg_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign pipe_reset = pipe_reset_q;
  assign start      = start_q;
  assign n_out      = n_out_q;
  assign out_valid  = out_valid_q;
  assign state      = state_q;

endmodule
